// File: rtl/enc_scan_pkg.sv
// Shared definitions for the encoder scanner: FSM state codes and the
// saturation limits used by every per-channel accumulator.
package enc_scan_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STROBE = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_ACCUM  = 2'd3;

    // Two's-complement limits of a w-bit signed value (w up to 31).
    function automatic int sat_hi(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int sat_lo(input int w);
        return -(1 << (w - 1));
    endfunction

endpackage

// File: rtl/enc_acc.sv
// One channel's signed saturating accumulator with a sticky overflow flag.
// A host clear in the same cycle as an add keeps the new delta, so no count is lost.
module enc_acc
    import enc_scan_pkg::*;
#(
    parameter int CNT_W = 2,
    parameter int ACC_W = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    add_en,
    input  logic                    clr,
    input  logic [CNT_W-1:0]        delta,
    output logic signed [ACC_W-1:0] acc,
    output logic                    ovf
);

    localparam logic signed [ACC_W:0] HI = (ACC_W + 1)'(sat_hi(ACC_W));
    localparam logic signed [ACC_W:0] LO = (ACC_W + 1)'(sat_lo(ACC_W));

    logic signed [ACC_W-1:0] dext;
    logic signed [ACC_W:0]   sum;

    assign dext = {{(ACC_W - CNT_W){delta[CNT_W-1]}}, delta};
    assign sum  = {acc[ACC_W-1], acc} + {dext[ACC_W-1], dext};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            // A delta fits in ACC_W bits, so starting over from it never saturates.
            acc <= add_en ? dext : '0;
            ovf <= 1'b0;
        end else if (add_en && (dext != '0)) begin
            if (sum > HI) begin
                acc <= HI[ACC_W-1:0];
                ovf <= 1'b1;
            end else if (sum < LO) begin
                acc <= LO[ACC_W-1:0];
                ovf <= 1'b1;
            end else begin
                acc <= sum[ACC_W-1:0];
            end
        end
    end

endmodule

// File: rtl/enc_scan.sv
// Round-robin scanner that drains CH encoder decoders into per-channel accumulators.
// Host reads return the selected accumulator and clear it together with its flag.
//
// state     | meaning
// ST_IDLE   | waiting for a divider tick to start a round at channel 0
// ST_STROBE | enc_rd_o[ch] high, delta captured from enc_cnt_i
// ST_WAIT   | one spare cycle while the decoder finishes its clear
// ST_ACCUM  | delta added into acc[ch]; advance or finish the round
module enc_scan
    import enc_scan_pkg::*;
#(
    parameter int CH       = 4,
    parameter int CNT_W    = 2,
    parameter int ACC_W    = 8,
    parameter int SCAN_DIV = 256,
    localparam int SEL_W   = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [CH*CNT_W-1:0]     enc_cnt_i,
    output logic [CH-1:0]           enc_rd_o,
    input  logic [SEL_W-1:0]        sel_i,
    input  logic                    rd_i,
    output logic signed [ACC_W-1:0] data_o,
    output logic [CH-1:0]           ovf_o,
    output logic                    irq_o
);

    localparam int DIV_W = $clog2(SCAN_DIV);

    logic [DIV_W-1:0]        div;
    logic                    tick;
    logic [1:0]              state;
    logic [SEL_W-1:0]        ch;
    logic [CNT_W-1:0]        delta;
    logic [CNT_W-1:0]        cnt_sel;
    logic signed [ACC_W-1:0] acc [CH];
    logic signed [ACC_W-1:0] rd_val;
    logic [CH-1:0]           add_en;
    logic [CH-1:0]           clr;
    logic [CH-1:0]           acc_nz;
    logic [CH-1:0]           ovf;

    // Terminal count at zero, so the first tick comes on the first clock after reset.
    assign tick = (div == '0);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            div <= '0;
        end else if (tick) begin
            div <= DIV_W'(SCAN_DIV - 1);
        end else begin
            div <= div - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= ST_IDLE;
            ch    <= '0;
            delta <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (tick) begin
                        state <= ST_STROBE;
                        ch    <= '0;
                    end
                end
                ST_STROBE: begin
                    delta <= cnt_sel;
                    state <= ST_WAIT;
                end
                ST_WAIT: state <= ST_ACCUM;
                ST_ACCUM: begin
                    if (ch == SEL_W'(CH - 1)) begin
                        state <= ST_IDLE;
                    end else begin
                        ch    <= ch + 1'b1;
                        state <= ST_STROBE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_sel  = '0;
        enc_rd_o = '0;
        rd_val   = '0;
        for (int k = 0; k < CH; k++) begin
            if (ch == SEL_W'(k)) begin
                cnt_sel     = enc_cnt_i[k*CNT_W +: CNT_W];
                enc_rd_o[k] = (state == ST_STROBE);
            end
            // Out-of-range selects match no channel and read back zero.
            if (sel_i == SEL_W'(k)) begin
                rd_val = acc[k];
            end
        end
    end

    for (genvar k = 0; k < CH; k++) begin : g_ch
        assign add_en[k] = (state == ST_ACCUM) && (ch == SEL_W'(k));
        assign clr[k]    = rd_i && (sel_i == SEL_W'(k));
        assign acc_nz[k] = (acc[k] != '0);

        enc_acc #(
            .CNT_W (CNT_W),
            .ACC_W (ACC_W)
        ) u_acc (
            .clk_i   (clk_i),
            .rst_n_i (rst_n_i),
            .add_en  (add_en[k]),
            .clr     (clr[k]),
            .delta   (delta),
            .acc     (acc[k]),
            .ovf     (ovf[k])
        );
    end

    assign ovf_o = ovf;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_o <= '0;
            irq_o  <= 1'b0;
        end else begin
            if (rd_i) begin
                data_o <= rd_val;
            end
            irq_o <= (|acc_nz) | (|ovf);
        end
    end

endmodule

// File: tb/tb_enc_scan.sv
// Directed bench for enc_scan: a CH=4 instance for the main scenarios and a
// CH=5 instance where out-of-range channel selects are representable.
module tb_enc_scan;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;

    logic [7:0]        enc_cnt = '0;
    logic [3:0]        enc_rd;
    logic [1:0]        sel = '0;
    logic              rd = 1'b0;
    logic signed [7:0] data;
    logic [3:0]        ovf;
    logic              irq;

    logic [9:0]        enc5 = '0;
    logic [4:0]        enc_rd5;
    logic [2:0]        sel5 = '0;
    logic              rd5 = 1'b0;
    logic signed [7:0] data5;
    logic [4:0]        ovf5;
    logic              irq5;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    enc_scan #(.CH(4), .CNT_W(2), .ACC_W(8), .SCAN_DIV(16)) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .enc_cnt_i (enc_cnt),
        .enc_rd_o  (enc_rd),
        .sel_i     (sel),
        .rd_i      (rd),
        .data_o    (data),
        .ovf_o     (ovf),
        .irq_o     (irq)
    );

    enc_scan #(.CH(5), .CNT_W(2), .ACC_W(8), .SCAN_DIV(20)) dut5 (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .enc_cnt_i (enc5),
        .enc_rd_o  (enc_rd5),
        .sel_i     (sel5),
        .rd_i      (rd5),
        .data_o    (data5),
        .ovf_o     (ovf5),
        .irq_o     (irq5)
    );

    // Caller sits at a negedge; returns at the negedge after the read edge.
    task automatic do_read(input int s, output logic signed [7:0] v);
        sel = 2'(s);
        rd  = 1'b1;
        @(negedge clk);
        rd  = 1'b0;
        v   = data;
    endtask

    task automatic do_read5(input int s, output logic signed [7:0] v);
        sel5 = 3'(s);
        rd5  = 1'b1;
        @(negedge clk);
        rd5  = 1'b0;
        v    = data5;
    endtask

    // Advance to the next negedge that shows enc_rd[k] high, bounded.
    task automatic wait_rd(input int k, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (enc_rd[k]) begin
                seen = 1'b1;
                break;
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s: no strobe on ch%0d got=timeout want=pulse", tag, k);
        end
    endtask

    task automatic wait_rd5(input int k);
        bit seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (enc_rd5[k]) begin
                seen = 1'b1;
                break;
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL oob_wait: no strobe on ch%0d got=timeout want=pulse", k);
        end
    endtask

    task automatic test_reset;
        #2;
        total++; if (enc_rd !== 4'b0000) begin bad++; $display("FAIL rst_enc_rd got=%b want=0000", enc_rd); end
        total++; if (data !== 8'h00) begin bad++; $display("FAIL rst_data got=%h want=00", data); end
        total++; if (ovf !== 4'b0000) begin bad++; $display("FAIL rst_ovf got=%b want=0000", ovf); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq got=%b want=0", irq); end
        repeat (3) @(negedge clk);
        total++; if (enc_rd !== 4'b0000) begin bad++; $display("FAIL rst_clocked_enc_rd got=%b want=0000", enc_rd); end
    endtask

    // Each channel's count vanishes one cycle after its strobe, like a decoder clear,
    // so a capture taken on any cycle but the strobe cycle would see zero.
    task automatic test_trace;
        logic [3:0] exp_tr [13] = '{4'b0001, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000,
                                    4'b0100, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000,
                                    4'b0000};
        logic [3:0] prev = '0;
        logic signed [7:0] v;
        enc_cnt = 8'b11_01_11_01;
        rst_n = 1'b1;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                if (prev[k]) enc_cnt[2*k +: 2] = 2'b00;
            end
            prev = enc_rd;
            total++;
            if (enc_rd !== exp_tr[i]) begin
                bad++;
                $display("FAIL trace[%0d] got=%b want=%b", i, enc_rd, exp_tr[i]);
            end
        end
        do_read(0, v); total++; if (v !== 8'h01) begin bad++; $display("FAIL trace_acc0 got=%h want=01", v); end
        do_read(1, v); total++; if (v !== 8'hFF) begin bad++; $display("FAIL trace_acc1 got=%h want=ff", v); end
        do_read(2, v); total++; if (v !== 8'h01) begin bad++; $display("FAIL trace_acc2 got=%h want=01", v); end
        do_read(3, v); total++; if (v !== 8'hFF) begin bad++; $display("FAIL trace_acc3 got=%h want=ff", v); end
        @(negedge clk);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL trace_irq_clear got=%b want=0", irq); end
    endtask

    task automatic test_hold;
        logic signed [7:0] v;
        enc_cnt = 8'b00_00_01_00;
        for (int r = 0; r < 3; r++) wait_rd(1, "hold_wait");
        @(negedge clk);
        enc_cnt = '0;
        repeat (2) @(negedge clk);
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL hold_irq_set got=%b want=1", irq); end
        do_read(1, v);
        total++; if (v !== 8'h03) begin bad++; $display("FAIL hold_read got=%h want=03", v); end
        @(negedge clk);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL hold_irq_fall got=%b want=0", irq); end
        repeat (5) @(negedge clk);
        total++; if (data !== 8'h03) begin bad++; $display("FAIL hold_data_stable got=%h want=03", data); end
    endtask

    task automatic test_saturate;
        logic signed [7:0] v;
        enc_cnt = 8'b00_11_00_00;
        for (int r = 0; r < 200; r++) wait_rd(2, "sat_wait");
        @(negedge clk);
        enc_cnt = '0;
        repeat (2) @(negedge clk);
        total++; if (ovf !== 4'b0100) begin bad++; $display("FAIL sat_ovf got=%b want=0100", ovf); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL sat_irq got=%b want=1", irq); end
        do_read(2, v);
        total++; if (v !== 8'h80) begin bad++; $display("FAIL sat_read got=%h want=80", v); end
        total++; if (ovf !== 4'b0000) begin bad++; $display("FAIL sat_ovf_clear got=%b want=0000", ovf); end
        do_read(2, v);
        total++; if (v !== 8'h00) begin bad++; $display("FAIL sat_acc_cleared got=%h want=00", v); end
    endtask

    task automatic test_collide;
        logic signed [7:0] v;
        enc_cnt = 8'b00_00_00_01;
        for (int r = 0; r < 6; r++) wait_rd(0, "col_wait");
        @(negedge clk);
        enc_cnt = '0;
        @(negedge clk);
        do_read(0, v);
        total++; if (v !== 8'h05) begin bad++; $display("FAIL collide_read got=%h want=05", v); end
        do_read(0, v);
        total++; if (v !== 8'h01) begin bad++; $display("FAIL collide_after got=%h want=01", v); end
        total++; if (ovf !== 4'b0000) begin bad++; $display("FAIL collide_ovf got=%b want=0000", ovf); end
    endtask

    task automatic test_reset_mid;
        logic signed [7:0] v;
        enc_cnt = 8'b01_01_01_01;
        wait_rd(2, "mid_wait");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (enc_rd !== 4'b0000) begin bad++; $display("FAIL mid_enc_rd got=%b want=0000", enc_rd); end
        total++; if (data !== 8'h00) begin bad++; $display("FAIL mid_data got=%h want=00", data); end
        total++; if (ovf !== 4'b0000) begin bad++; $display("FAIL mid_ovf got=%b want=0000", ovf); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL mid_irq got=%b want=0", irq); end
        enc_cnt = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (enc_rd !== 4'b0001) begin bad++; $display("FAIL mid_first_pulse got=%b want=0001", enc_rd); end
        repeat (20) @(negedge clk);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL mid_irq_after got=%b want=0", irq); end
        do_read(1, v);
        total++; if (v !== 8'h00) begin bad++; $display("FAIL mid_acc1 got=%h want=00", v); end
        do_read(2, v);
        total++; if (v !== 8'h00) begin bad++; $display("FAIL mid_acc2 got=%h want=00", v); end
    endtask

    task automatic test_oob;
        logic signed [7:0] v;
        wait_rd5(0);
        enc5 = 10'b01_01_01_01_01;
        wait_rd5(4);
        @(negedge clk);
        enc5 = '0;
        repeat (2) @(negedge clk);
        do_read5(3, v);
        total++; if (v !== 8'h01) begin bad++; $display("FAIL oob_pre_read got=%h want=01", v); end
        do_read5(5, v);
        total++; if (v !== 8'h00) begin bad++; $display("FAIL oob_sel5 got=%h want=00", v); end
        do_read5(7, v);
        total++; if (v !== 8'h00) begin bad++; $display("FAIL oob_sel7 got=%h want=00", v); end
        total++; if (irq5 !== 1'b1) begin bad++; $display("FAIL oob_irq got=%b want=1", irq5); end
        do_read5(4, v);
        total++; if (v !== 8'h01) begin bad++; $display("FAIL oob_acc4 got=%h want=01", v); end
        do_read5(0, v);
        total++; if (v !== 8'h01) begin bad++; $display("FAIL oob_acc0 got=%h want=01", v); end
    endtask

    initial begin
        test_reset;
        test_trace;
        test_hold;
        test_saturate;
        test_collide;
        test_reset_mid;
        test_oob;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
